// File: rtl/prod_accum.sv
`default_nettype none
// ============================================================================
//  Module   : prod_accum
//  Purpose  : Sums N_TERMS unsigned 4-bit products from the 2x2 multiplier
//             stage into an ACC_W-bit result. The result is handed off with a
//             valid/ready handshake. A sticky carry-out flag marks a wrapped
//             sum.
//  Ports    : clk        - single clock, all state updates on the rising edge
//             rst        - asynchronous active-high reset
//             start      - pulse that begins a new accumulation (IDLE only)
//             product    - 4-bit unsigned product
//             in_valid   - product is valid this cycle
//             in_ready   - block accepts a product this cycle (ACC)
//             sum        - registered accumulated result
//             out_valid  - sum is complete and stable (DONE)
//             out_ready  - consumer accepts sum
//             busy       - high in ACC or DONE
//             ovf        - sticky carry-out flag for the current result
//  Revision : 1.0  initial release
// ============================================================================
module prod_accum #(
    parameter int N_TERMS = 4,   // products per result, 1..255
    parameter int ACC_W   = 8    // accumulator width, >= 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       product,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Count value at which the incoming product is the final term.
    localparam logic [7:0] c_last_cnt = 8'(N_TERMS - 1);

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [ACC_W-1:0] r_sum;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    // One extra bit on the adder captures the carry out of bit ACC_W-1.
    logic [ACC_W:0]   w_add;
    assign w_add = {1'b0, r_sum} + {{(ACC_W-3){1'b0}}, product};

    // Handshake outputs are registered alongside the state, so each
    // transition also loads the output values of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_sum       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_ACC;
                        r_cnt      <= 8'd0;
                        r_sum      <= '0;
                        r_ovf      <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_ACC: begin
                    if (in_valid) begin
                        r_sum <= w_add[ACC_W-1:0];
                        r_cnt <= r_cnt + 8'd1;
                        if (w_add[ACC_W]) begin
                            r_ovf <= 1'b1;
                        end
                        if (r_cnt == c_last_cnt) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a quiet IDLE.
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire
